scan_rx_tag_emul: RTL and testbench

- Receive-side emulator of the tag-chip scan port. It deserializes the two-phase scan stream (scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip) that the hop controller drives out through front-panel GPIO.
- It recovers each loaded hop word and flags protocol violations.
- It is used in loopback builds and benches in place of the real chip, sampling the GPIO input bits on the main radio clock.

---
 rtl/scan_rx_tag_emul.sv | 183 ++++++++++++++++++
 tb/tb_scan_rx_tag_emul.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/scan_rx_tag_emul.sv
// Receive-side emulator of the tag-chip scan port: deserializes the two-phase scan stream
// and recovers loaded hop words. Optional watchdog enabled by macro SCAN_RX_TIMEOUT_EN.
module scan_rx_tag_emul #(
    parameter int TX_BITS_WIDTH  = 128,
    parameter int BIT_CNT_WIDTH  = 7,
    parameter int NTX_BITS       = 78,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scan_id,
    input  logic                     scan_phi,
    input  logic                     scan_phi_bar,
    input  logic                     scan_data_in,
    input  logic                     scan_load_chip,
    output logic [TX_BITS_WIDTH-1:0] data_out,
    output logic                     data_valid,
    output logic [BIT_CNT_WIDTH-1:0] nbits_cnt,
    output logic [15:0]              frame_cnt,
    output logic                     len_err,
    output logic                     phase_err,
    output logic                     timeout_err,
    output logic                     busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    localparam int I_ID = 0, I_PHI = 1, I_PHIB = 2, I_DATA = 3, I_LOAD = 4;
    localparam logic [TX_BITS_WIDTH-1:0] NTX_MASK =
        {TX_BITS_WIDTH{1'b1}} >> (TX_BITS_WIDTH - NTX_BITS);

    typedef enum logic [1:0] {IDLE, WAIT_PHI, WAIT_PHIB} state_t;

    logic [SYNC_STAGES-1:0][4:0] sync_r;
    logic [4:0]                  lvl_q, rise_q, fall_q, stage;

    state_t                   state, state_n;
    logic [TX_BITS_WIDTH-1:0] shift_reg, shift_n, data_out_n;
    logic                     master, master_n;
    logic [BIT_CNT_WIDTH-1:0] nbits_n;
    logic [15:0]              frame_n;
    logic                     dv_n, len_n, phase_n, tmo_err_n;
    logic                     phi_ev, phib_ev;

    assign stage   = sync_r[SYNC_STAGES-1];
    // Coincident phase strobes cancel each other; the overlap check flags them.
    assign phi_ev  = rise_q[I_PHI] & ~rise_q[I_PHIB];
    assign phib_ev = rise_q[I_PHIB] & ~rise_q[I_PHI];
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
            lvl_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0],
                       {scan_load_chip, scan_data_in, scan_phi_bar, scan_phi, scan_id}};
            lvl_q  <= stage;
            rise_q <= stage & ~lvl_q;
            fall_q <= ~stage & lvl_q;
        end
    end

`ifdef SCAN_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic          tmo_fire;

    always_comb begin
        tmo_n    = TW'(TIMEOUT_CYCLES - 1);
        tmo_fire = 1'b0;
        if (state != IDLE && !(rise_q[I_PHI] | rise_q[I_PHIB] | rise_q[I_LOAD])) begin
            if (tmo_cnt == '0) tmo_fire = 1'b1;
            else               tmo_n    = tmo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
        else       tmo_cnt <= tmo_n;
    end
`endif

    always_comb begin
        state_n    = state;
        shift_n    = shift_reg;
        master_n   = master;
        nbits_n    = nbits_cnt;
        data_out_n = data_out;
        frame_n    = frame_cnt;
        dv_n       = 1'b0;
        len_n      = len_err;
        tmo_err_n  = timeout_err;
        phase_n    = phase_err | (lvl_q[I_PHI] & lvl_q[I_PHIB]);

        case (state)
            IDLE: begin
                if (rise_q[I_ID]) begin
                    shift_n = '0;
                    nbits_n = '0;
                    state_n = WAIT_PHI;
                end
            end
            WAIT_PHI: begin
                if (rise_q[I_LOAD]) begin
                    if (nbits_cnt == BIT_CNT_WIDTH'(NTX_BITS)) begin
                        data_out_n = shift_reg & NTX_MASK;
                        dv_n       = 1'b1;
                        frame_n    = frame_cnt + 16'd1;
                    end else begin
                        len_n = 1'b1;
                    end
                    state_n = IDLE;
                end else if (fall_q[I_ID]) begin
                    state_n = IDLE;
                end else if (phi_ev) begin
                    master_n = lvl_q[I_DATA];
                    state_n  = WAIT_PHIB;
                end else if (phib_ev) begin
                    phase_n = 1'b1;
                end
            end
            WAIT_PHIB: begin
                if (rise_q[I_LOAD]) begin
                    phase_n = 1'b1;
                    state_n = IDLE;
                end else if (fall_q[I_ID]) begin
                    state_n = IDLE;
                end else if (phib_ev) begin
                    shift_n = {shift_reg[TX_BITS_WIDTH-2:0], master};
                    if (nbits_cnt != '1) nbits_n = nbits_cnt + 1'b1;
                    state_n = WAIT_PHI;
                end else if (phi_ev) begin
                    phase_n  = 1'b1;
                    master_n = lvl_q[I_DATA];
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef SCAN_RX_TIMEOUT_EN
        if (tmo_fire) begin
            state_n   = IDLE;
            tmo_err_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            master      <= 1'b0;
            nbits_cnt   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_cnt   <= '0;
            len_err     <= 1'b0;
            phase_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            shift_reg   <= shift_n;
            master      <= master_n;
            nbits_cnt   <= nbits_n;
            data_out    <= data_out_n;
            data_valid  <= dv_n;
            frame_cnt   <= frame_n;
            len_err     <= len_n;
            phase_err   <= phase_n;
            timeout_err <= tmo_err_n;
        end
    end

endmodule

// File: tb/tb_scan_rx_tag_emul.sv
// Directed bench for scan_rx_tag_emul: frame loads, length/phase errors, abort, reset, watchdog.
module tb_scan_rx_tag_emul;

    logic         clk = 1'b0;
    logic         reset;
    logic         scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip;
    logic [127:0] data_out;
    logic         data_valid;
    logic [6:0]   nbits_cnt;
    logic [15:0]  frame_cnt;
    logic         len_err, phase_err, timeout_err, busy;

    int total = 0;
    int bad   = 0;
    int dv_cnt = 0;
    int dv_mark;

    logic [127:0] pat_a   = 128'h2A5A5A5A5;
    logic [127:0] pat_b   = 128'h3123456789ABCDEF0123;
    logic [127:0] pat_one = 128'h3FFF_FFFF_FFFF_FFFF_FFFF;

    scan_rx_tag_emul #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .scan_id(scan_id), .scan_phi(scan_phi), .scan_phi_bar(scan_phi_bar),
        .scan_data_in(scan_data_in), .scan_load_chip(scan_load_chip),
        .data_out(data_out), .data_valid(data_valid), .nbits_cnt(nbits_cnt),
        .frame_cnt(frame_cnt), .len_err(len_err), .phase_err(phase_err),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (data_valid) dv_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        scan_data_in = b;
        scan_phi = 1'b1;     tick(10);
        scan_phi = 1'b0;     tick(2);
        scan_phi_bar = 1'b1; tick(6);
        scan_phi_bar = 1'b0; tick(2);
    endtask

    // MSB-first from bit 77 downward.
    task automatic send_bits(input logic [127:0] pat, input int n);
        for (int i = 0; i < n; i++) send_bit(pat[77-i]);
    endtask

    task automatic id_up();
        scan_id = 1'b1; tick(10);
    endtask

    task automatic load_and_drop();
        dv_mark = dv_cnt;
        scan_load_chip = 1'b1; tick(10);
        scan_load_chip = 1'b0; tick(5);
        scan_id = 1'b0;        tick(10);
    endtask

    initial begin
        reset = 1'b1;
        scan_id = 0; scan_phi = 0; scan_phi_bar = 0; scan_data_in = 0; scan_load_chip = 0;
        tick(4);
        check("rst_data_out", data_out, 0);
        check("rst_frame_cnt", {112'd0, frame_cnt}, 0);
        check("rst_flags", {len_err, phase_err, timeout_err, busy, data_valid}, 0);
        check("rst_nbits", {121'd0, nbits_cnt}, 0);
        reset = 1'b0;
        tick(5);

        // Clean frame A
        id_up();
        check("busy_after_id", {127'd0, busy}, 1);
        send_bits(pat_a, 78);
        check("a_nbits", {121'd0, nbits_cnt}, 78);
        load_and_drop();
        check("a_data_out", data_out, pat_a);
        check("a_dv_pulses", 128'(dv_cnt - dv_mark), 1);
        check("a_frame_cnt", {112'd0, frame_cnt}, 1);
        check("a_flags", {len_err, phase_err, timeout_err, busy}, 0);

        // Short frame: 77 bits
        id_up();
        send_bits(pat_a, 77);
        check("short_nbits", {121'd0, nbits_cnt}, 77);
        load_and_drop();
        check("short_len_err", {127'd0, len_err}, 1);
        check("short_no_dv", 128'(dv_cnt - dv_mark), 0);
        check("short_data_keep", data_out, pat_a);
        check("short_frame_cnt", {112'd0, frame_cnt}, 1);
        check("short_phase_ok", {127'd0, phase_err}, 0);

        // Phase overlap then clean frame B
        scan_phi = 1'b1; scan_phi_bar = 1'b1; tick(5);
        scan_phi = 1'b0; scan_phi_bar = 1'b0; tick(10);
        check("ovl_phase_err", {127'd0, phase_err}, 1);
        check("ovl_busy", {127'd0, busy}, 0);
        id_up();
        send_bits(pat_b, 78);
        load_and_drop();
        check("b_data_out", data_out, pat_b);
        check("b_dv_pulses", 128'(dv_cnt - dv_mark), 1);
        check("b_frame_cnt", {112'd0, frame_cnt}, 2);

        // Reset mid-frame
        id_up();
        send_bits(pat_a, 30);
        check("mid_nbits", {121'd0, nbits_cnt}, 30);
        reset = 1'b1; tick(2);
        check("mrst_data_out", data_out, 0);
        check("mrst_frame_cnt", {112'd0, frame_cnt}, 0);
        check("mrst_flags", {len_err, phase_err, timeout_err, busy, data_valid}, 0);
        check("mrst_nbits", {121'd0, nbits_cnt}, 0);
        scan_id = 1'b0; tick(5);
        reset = 1'b0; tick(10);

        // 40-bit abort, then all-ones frame
        id_up();
        send_bits(pat_a, 40);
        scan_id = 1'b0; tick(10);
        check("abort_busy", {127'd0, busy}, 0);
        check("abort_flags", {len_err, phase_err, timeout_err}, 0);
        id_up();
        send_bits(pat_one, 78);
        load_and_drop();
        check("ones_data_out", data_out, pat_one);
        check("ones_dv_pulses", 128'(dv_cnt - dv_mark), 1);
        check("ones_frame_cnt", {112'd0, frame_cnt}, 1);
        check("ones_flags", {len_err, phase_err, timeout_err}, 0);

        // Watchdog: 10 bits then idle
        id_up();
        send_bits(pat_a, 10);
        tick(100);
`ifdef SCAN_RX_TIMEOUT_EN
        check("tmo_err", {127'd0, timeout_err}, 1);
        check("tmo_busy", {127'd0, busy}, 0);
`else
        check("notmo_err", {127'd0, timeout_err}, 0);
        check("notmo_busy", {127'd0, busy}, 1);
        check("notmo_nbits", {121'd0, nbits_cnt}, 10);
`endif
        scan_id = 1'b0; tick(10);
        check("end_busy", {127'd0, busy}, 0);
        check("end_data_keep", data_out, pat_one);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
